// File: rtl/counter_seq_ctrl.sv
// Start/stop/pause sequencer driving a WIDTH-bit count with one-shot or auto-reload terminal handling.
// Optional down-count mode is enabled by defining COUNTER_SEQ_DOWN_EN.
module counter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_SEQ_DOWN_EN
    input  logic             down,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_lim;
    logic             r_mode;
    logic             w_down;
    logic             w_accept;
    logic             w_at_term;
    logic [WIDTH-1:0] w_term_val;
    logic [WIDTH-1:0] w_reload_val;

    // Limit, mode and direction are captured only when a start is actually accepted.
    assign w_accept     = start && !stop && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_term_val   = w_down ? '0 : r_lim;
    assign w_reload_val = w_down ? r_lim : '0;
    assign w_at_term    = (r_out == w_term_val);
    assign out          = r_out;

`ifdef COUNTER_SEQ_DOWN_EN
    logic r_down;
    assign w_down = r_down;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_down <= 1'b0;
        end else if (w_accept) begin
            r_down <= down;
        end
    end
`else
    assign w_down = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_LOAD;
                S_LOAD:  w_next = S_RUN;
                S_RUN:   if (!pause && w_at_term && !r_mode) w_next = S_DONE;
                S_DONE:  if (start) w_next = S_LOAD;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_LOAD) || (r_state == S_RUN);
        done = (r_state == S_DONE);
        tc   = (r_state == S_RUN) && !pause && !stop && w_at_term;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out  <= '0;
            r_lim  <= '0;
            r_mode <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lim  <= limit;
                r_mode <= auto_reload;
            end
            if (stop) begin
                r_out <= '0;
            end else begin
                case (r_state)
                    S_LOAD: r_out <= w_down ? r_lim : '0;
                    S_RUN: begin
                        if (!pause) begin
                            if (w_at_term) begin
                                if (r_mode) r_out <= w_reload_val;
                            end else begin
                                r_out <= w_down ? (r_out - WIDTH'(1)) : (r_out + WIDTH'(1));
                            end
                        end
                    end
                    default: r_out <= r_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_counter_seq_ctrl;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] limit;
    logic         down;
    logic [W-1:0] out;
    logic         busy;
    logic         tc;
    logic         done;

    typedef struct {
        logic [W-1:0] out;
        logic         busy;
        logic         tc;
        logic         done;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .limit       (limit),
`ifdef COUNTER_SEQ_DOWN_EN
        .down        (down),
`endif
        .out         (out),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one expectation per cycle, sampled on the falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (out !== e.out) begin
                errors++;
                $display("FAIL %s out: got %0d expected %0d", e.tag, out, e.out);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
            end
            checks++;
            if (tc !== e.tc) begin
                errors++;
                $display("FAIL %s tc: got %b expected %b", e.tag, tc, e.tc);
            end
            checks++;
            if (done !== e.done) begin
                errors++;
                $display("FAIL %s done: got %b expected %b", e.tag, done, e.done);
            end
        end
    end

    // Drive this cycle's controls, queue the outputs expected during it, then advance one edge.
    task automatic step(input logic rst, input logic st, input logic sp, input logic pa,
                        input logic [W-1:0] eo, input logic eb, input logic et, input logic ed,
                        input string tag);
        exp_t e;
        reset = rst;
        start = st;
        stop  = sp;
        pause = pa;
        e.out  = eo;
        e.busy = eb;
        e.tc   = et;
        e.done = ed;
        e.tag  = tag;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        auto_reload = 1'b0; limit = '0; down = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset1");

        // One-shot, limit 5
        limit = 5; auto_reload = 0;
        step(0, 1, 0, 0, 0, 0, 0, 0, "t1_idle_start");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t1_load");
        for (int i = 0; i <= 5; i++)
            step(0, 0, 0, 0, W'(i), 1, (i == 5), 0, "t1_run");
        step(0, 0, 0, 0, 5, 0, 0, 1, "t1_done0");
        step(0, 0, 0, 0, 5, 0, 0, 1, "t1_done1");

        // Auto-reload, limit 3, restarted from DONE
        limit = 3; auto_reload = 1;
        step(0, 1, 0, 0, 5, 0, 0, 1, "t2_done_start");
        step(0, 0, 0, 0, 5, 1, 0, 0, "t2_load");
        for (int i = 0; i < 12; i++)
            step(0, 0, 0, 0, W'(i % 4), 1, ((i % 4) == 3), 0, "t2_run");
        step(0, 0, 1, 0, 0, 1, 0, 0, "t2_stop");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t2_idle");

        // One-shot limit 9 with pause, ignored mid-run start, pause at terminal
        limit = 9; auto_reload = 0;
        step(0, 1, 0, 0, 0, 0, 0, 0, "t3_idle_start");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t3_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t3_run0");
        step(0, 0, 0, 0, 1, 1, 0, 0, "t3_run1");
        limit = 2; auto_reload = 1;
        step(0, 1, 0, 0, 2, 1, 0, 0, "t3_start_ignored");
        step(0, 0, 0, 0, 3, 1, 0, 0, "t3_run3");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, 4, 1, 0, 0, "t3_paused");
        for (int i = 4; i <= 8; i++)
            step(0, 0, 0, 0, W'(i), 1, 0, 0, "t3_resume");
        step(0, 0, 0, 1, 9, 1, 0, 0, "t3_pause_at_term");
        step(0, 0, 0, 0, 9, 1, 1, 0, "t3_term");
        step(0, 0, 0, 0, 9, 0, 0, 1, "t3_done");

        // Stop with simultaneous start
        limit = 7; auto_reload = 0;
        step(0, 1, 0, 0, 9, 0, 0, 1, "t4_done_start");
        step(0, 0, 0, 0, 9, 1, 0, 0, "t4_load");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, W'(i), 1, 0, 0, "t4_run");
        step(0, 1, 1, 0, 3, 1, 0, 0, "t4_stop_start");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t4_idle");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t4_idle2");

        // limit 0 with auto-reload; stop on a terminal cycle suppresses tc
        limit = 0; auto_reload = 1;
        step(0, 1, 0, 0, 0, 0, 0, 0, "t5_idle_start");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t5_load");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, 1, 0, "t5_lim0_run");
        step(0, 0, 0, 1, 0, 1, 0, 0, "t5_lim0_pause");
        step(0, 0, 0, 0, 0, 1, 1, 0, "t5_lim0_run2");
        step(0, 0, 1, 0, 0, 1, 0, 0, "t5_stop_at_term");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t5_idle");

        // Reset mid-run
        limit = 6; auto_reload = 0;
        step(0, 1, 0, 0, 0, 0, 0, 0, "t5b_start");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t5b_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t5b_run0");
        step(0, 0, 0, 0, 1, 1, 0, 0, "t5b_run1");
        step(1, 0, 0, 0, 2, 1, 0, 0, "t5b_reset_edge");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t5b_after_reset");

        // Full-range auto-reload, limit 15
        limit = 15; auto_reload = 1;
        step(0, 1, 0, 0, 0, 0, 0, 0, "fr_start");
        step(0, 0, 0, 0, 0, 1, 0, 0, "fr_load");
        for (int i = 0; i <= 17; i++)
            step(0, 0, 0, 0, W'(i % 16), 1, ((i % 16) == 15), 0, "fr_run");
        step(0, 0, 1, 0, 2, 1, 0, 0, "fr_stop");
        step(0, 0, 0, 0, 0, 0, 0, 0, "fr_idle");

`ifdef COUNTER_SEQ_DOWN_EN
        // Down-count one-shot, limit 4
        limit = 4; auto_reload = 0; down = 1;
        step(0, 1, 0, 0, 0, 0, 0, 0, "t6_start");
        down = 0;
        step(0, 0, 0, 0, 0, 1, 0, 0, "t6_load");
        for (int i = 4; i >= 0; i--)
            step(0, 0, 0, 0, W'(i), 1, (i == 0), 0, "t6_run");
        step(0, 0, 0, 0, 0, 0, 0, 1, "t6_done0");
        step(0, 0, 0, 0, 0, 0, 0, 1, "t6_done1");
`endif

        begin
            int waited;
            waited = 0;
            while (q.size() > 0 && waited < 10) begin
                @(posedge clock);
                waited++;
            end
            if (q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d expectations left, expected 0", q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer that owns and drives a WIDTH-bit binary count datapath.
- Accepts start/stop/pause commands.
- Latches a terminal limit and mode at start, then runs the count in one-shot or auto-reload mode.
- Flags terminal count to downstream logic.
- Sits between control logic and the shared counter resource; the raw count is exported on out.

Parameters:
WIDTH, 4, width of count value and limit

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  command pulse; accepted only in IDLE or DONE
stop  input  1  abort; returns to IDLE from any state
pause  input  1  level; holds count while high in RUN
auto_reload  input  1  mode select, sampled on accepted start (1 = reload to 0 after terminal)
limit  input  WIDTH  terminal count value, sampled on accepted start
out  output  WIDTH  current count value
busy  output  1  high in LOAD and RUN
tc  output  1  terminal-count flag, combinational from registered state
done  output  1  high in DONE

Behaviour:
- Synchronous active-high reset, sampled on rising clock edge.
- Reset values: state = IDLE, out = 0, busy = 0, tc = 0, done = 0, latched limit lim_q = 0, latched mode = 0.
- Priority each cycle: reset > stop > start > pause > count.

States: IDLE, LOAD, RUN, DONE (2-bit encoding).

IDLE:
- out = 0.
- start & !stop -> LOAD.

LOAD (exactly one cycle):
- lim_q <= limit, mode_q <= auto_reload, out <= 0.
- Next state RUN.
- pause has no effect here.

RUN:
- pause high -> out holds, tc = 0, no state change.
- pause low and out == lim_q:
  - tc = 1 this cycle.
  - mode_q = 1 -> out <= 0, stay RUN.
  - mode_q = 0 -> DONE, out holds lim_q.
- pause low and out != lim_q: out <= out + 1 (modulo 2^WIDTH; cannot wrap before lim_q).

DONE:
- done = 1, out holds the final value.
- start -> LOAD (restart with fresh limit and mode sampled).

Latency:
- start sampled at edge k: LOAD after edge k, RUN with out = 0 after edge k+1.
- One-shot run with limit L: L+1 unpaused RUN cycles, tc during the last one, DONE on the following edge.

stop:
- From any state: next state IDLE, out <= 0, tc suppressed in the cycle stop is high.
- stop & start together: stop wins.

Other boundary rules:
- start while in LOAD or RUN is ignored; limit/auto_reload changes mid-run are ignored.
- limit = 0: tc on the first RUN cycle. With auto_reload = 1, tc stays high every unpaused cycle and out stays 0.
- limit = 2^WIDTH-1: full-range count, no overflow.
- Reset mid-RUN: all outputs return to reset values on that edge.

Optional Feature:
Macro: COUNTER_SEQ_DOWN_EN

Defined:
- Adds input port down (1 bit), sampled with limit on accepted start.
- down = 1:
  - LOAD sets out <= limit.
  - RUN decrements out.
  - Terminal condition is out == 0; tc rules are unchanged.
  - Auto-reload reloads out <= lim_q.
  - One-shot DONE holds 0.
- down = 0: behaves exactly as the up-count mode above.

Undefined:
- Port down is absent; up-count only.
- Logic is otherwise identical.

Test Plan:
1. reset=1 for 2 cycles, then limit=5, auto_reload=0, start pulse -> LOAD, then out 0,1,2,3,4,5; tc=1 only while out=5; next cycle done=1, busy=0, out=5 held.
2. limit=3, auto_reload=1, start, run 12 cycles -> out sequence 0,1,2,3,0,1,...; tc every 4th cycle; done stays 0; busy stays 1.
3. limit=9 one-shot, pause high for 3 cycles while out=4 -> out holds 4, tc=0; after release out reaches 9 three cycles later than unpaused.
4. limit=7 running, stop at out=3, with start asserted in the same cycle -> next cycle IDLE, out=0, busy=0, tc never asserted.
5. limit=0, auto_reload=1 -> tc high every RUN cycle, out stays 0. Separately, reset asserted mid-RUN at out=2 -> all outputs 0 after the edge.
6. With COUNTER_SEQ_DOWN_EN: down=1, limit=4, one-shot -> out 4,3,2,1,0; tc at 0; DONE holds 0.
